// File: rtl/address_sequencer_pkg.sv
// Shared types and width helpers for the address sequencer and its stream interface.
package address_sequencer_pkg;

   typedef enum logic [1:0] {
      CONTINUOUS = 2'd0,
      SINGLE     = 2'd1,
      PINGPONG   = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Output address is {bank, pointer, byte-offset zeros}.
   function automatic int addr_width(input int count_width, input int addr_lsb);
      return count_width + addr_lsb + 1;
   endfunction

   localparam int COUNT_WIDTH_DEFAULT = 13;
   localparam int ADDR_LSB_DEFAULT    = 2;
   localparam int ADDR_WIDTH          = addr_width(COUNT_WIDTH_DEFAULT, ADDR_LSB_DEFAULT);

   // The unused encoding 3 behaves as a one-shot pass.
   function automatic mode_t decode_mode(input logic [1:0] raw);
      case (raw)
         2'd0:    return CONTINUOUS;
         2'd2:    return PINGPONG;
         default: return SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/address_sequencer_if.sv
// Address stream from the sequencer to a BRAM port or DMA front end.
interface address_sequencer_if #(
   parameter int COUNT_WIDTH = 13,
   parameter int ADDR_LSB    = 2
);

   localparam int ADDR_WIDTH = address_sequencer_pkg::addr_width(COUNT_WIDTH, ADDR_LSB);

   logic [ADDR_WIDTH-1:0] address;
   logic                  valid;
   logic                  ready;
   logic                  last;
   logic                  wrap;
   logic                  done;
   logic                  bank;

   modport master (
      output address, valid, last, wrap, done, bank,
      input  ready
   );

   modport slave (
      input  address, valid, last, wrap, done, bank,
      output ready
   );

endinterface

// File: rtl/address_sequencer.sv
// Programmable-window address generator: start/stride/length with continuous,
// single-shot and ping-pong passes, delivered over a valid/ready stream.
module address_sequencer
   import address_sequencer_pkg::*;
#(
   parameter int COUNT_WIDTH = 13,
   parameter int ADDR_LSB    = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [COUNT_WIDTH-1:0] cfg_start,
   input  logic [COUNT_WIDTH-1:0] cfg_step,
   input  logic [COUNT_WIDTH-1:0] cfg_count_max,
   input  logic [1:0]             cfg_mode,
   input  logic                   load,
   input  logic                   halt,
   address_sequencer_if.master    bus
);

   state_t                 state_q, state_d;
   mode_t                  mode_q, mode_d;
   logic [COUNT_WIDTH-1:0] start_q, start_d;
   logic [COUNT_WIDTH-1:0] step_q, step_d;
   logic [COUNT_WIDTH-1:0] max_q, max_d;
   logic [COUNT_WIDTH-1:0] index_q, index_d;
   logic [COUNT_WIDTH-1:0] ptr_q, ptr_d;
   logic                   bank_q, bank_d;
   logic                   wrap_q, wrap_d;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         mode_q  <= CONTINUOUS;
         start_q <= '0;
         step_q  <= '0;
         max_q   <= '0;
         index_q <= '0;
         ptr_q   <= '0;
         bank_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         start_q <= start_d;
         step_q  <= step_d;
         max_q   <= max_d;
         index_q <= index_d;
         ptr_q   <= ptr_d;
         bank_q  <= bank_d;
         wrap_q  <= wrap_d;
      end
   end

   // NOTE: every signal gets its hold value before any branch, so no path
   // through the block leaves one unassigned and no latch can be inferred.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      start_d = start_q;
      step_d  = step_q;
      max_d   = max_q;
      index_d = index_q;
      ptr_d   = ptr_q;
      bank_d  = bank_q;
      wrap_d  = 1'b0;

      if (load) begin
         mode_d  = decode_mode(cfg_mode);
         start_d = cfg_start;
         step_d  = cfg_step;
         max_d   = cfg_count_max;
         index_d = '0;
         ptr_d   = cfg_start;
         bank_d  = 1'b0;
         state_d = RUN;
      end else if (halt) begin
         state_d = IDLE;
      end else if (state_q == RUN && bus.ready) begin
         if (index_q == max_q) begin
            case (mode_q)
               CONTINUOUS: begin
                  index_d = '0;
                  ptr_d   = start_q;
                  wrap_d  = 1'b1;
               end
               PINGPONG: begin
                  index_d = '0;
                  ptr_d   = start_q;
                  wrap_d  = 1'b1;
                  bank_d  = ~bank_q;
               end
               default: state_d = DONE;
            endcase
         end else begin
            index_d = index_q + COUNT_WIDTH'(1);
            ptr_d   = ptr_q + step_q;
         end
      end
   end

   // Outputs decode only registered state, so ready never reaches valid.
   assign bus.valid   = (state_q == RUN);
   assign bus.last    = (state_q == RUN) && (index_q == max_q);
   assign bus.done    = (state_q == DONE);
   assign bus.wrap    = wrap_q;
   assign bus.bank    = bank_q;
   assign bus.address = {bank_q, ptr_q, {ADDR_LSB{1'b0}}};

endmodule

// File: tb/tb_address_sequencer.sv
// Directed bench for address_sequencer: continuous, single, ping-pong wrap,
// mid-pass reload, load/halt priority and asynchronous reset.
module tb_address_sequencer;

   localparam int CW = 13;
   localparam int AL = 2;

   logic          clk = 1'b0;
   logic          resetn;
   logic [CW-1:0] cfg_start;
   logic [CW-1:0] cfg_step;
   logic [CW-1:0] cfg_count_max;
   logic [1:0]    cfg_mode;
   logic          load;
   logic          halt;

   int checks = 0;
   int errors = 0;

   address_sequencer_if #(.COUNT_WIDTH(CW), .ADDR_LSB(AL)) bus ();

   address_sequencer #(.COUNT_WIDTH(CW), .ADDR_LSB(AL)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .cfg_start     (cfg_start),
      .cfg_step      (cfg_step),
      .cfg_count_max (cfg_count_max),
      .cfg_mode      (cfg_mode),
      .load          (load),
      .halt          (halt),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_cfg(input int start, input int step, input int mx, input int mode);
      cfg_start     = CW'(start);
      cfg_step      = CW'(step);
      cfg_count_max = CW'(mx);
      cfg_mode      = 2'(mode);
   endtask

   initial begin
      int exp_addr;
      int exp_bank;
      resetn   = 1'b0;
      load     = 1'b0;
      halt     = 1'b0;
      bus.ready = 1'b0;
      set_cfg(0, 0, 0, 0);

      // Reset state, and nothing moves before the first load
      #2;
      check("rst_valid", 32'(bus.valid), 0);
      check("rst_addr",  32'(bus.address), 0);
      check("rst_done",  32'(bus.done), 0);
      tick(); tick();
      resetn = 1'b1;
      bus.ready = 1'b1;
      tick(); tick(); tick();
      check("idle_valid", 32'(bus.valid), 0);
      check("idle_last",  32'(bus.last), 0);
      check("idle_wrap",  32'(bus.wrap), 0);

      // Continuous: 16,20,24,28,16...
      set_cfg(4, 1, 3, 0);
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) tick();
         check("cont_valid", 32'(bus.valid), 1);
         check("cont_addr",  32'(bus.address), 32'(16 + 4 * (i % 4)));
         check("cont_last",  32'(bus.last), 32'(i % 4 == 3));
         check("cont_wrap",  32'(bus.wrap), 32'(i % 4 == 0 && i > 0));
         check("cont_bank",  32'(bus.bank), 0);
      end

      // Single shot with a stall
      set_cfg(0, 3, 2, 1);
      load = 1'b1;
      tick();
      load = 1'b0;
      check("sgl_addr0", 32'(bus.address), 0);
      check("sgl_done0", 32'(bus.done), 0);
      bus.ready = 1'b1; tick();
      check("sgl_addr1", 32'(bus.address), 12);
      bus.ready = 1'b0; tick();
      check("sgl_stall_addr", 32'(bus.address), 12);
      check("sgl_stall_last", 32'(bus.last), 0);
      bus.ready = 1'b1; tick();
      check("sgl_addr2", 32'(bus.address), 24);
      check("sgl_last2", 32'(bus.last), 1);
      tick();
      check("sgl_end_valid", 32'(bus.valid), 0);
      check("sgl_end_done",  32'(bus.done), 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("sgl_hold_valid", 32'(bus.valid), 0);
         check("sgl_hold_done",  32'(bus.done), 1);
         check("sgl_hold_last",  32'(bus.last), 0);
      end
      halt = 1'b1; tick(); halt = 1'b0;
      check("sgl_halt_done", 32'(bus.done), 0);

      // Ping-pong across the pointer modulo boundary
      set_cfg(8190, 1, 3, 2);
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) tick();
         exp_bank = (i / 4) % 2;
         exp_addr = (exp_bank << 15) | (((8190 + i % 4) % 8192) << 2);
         check("pp_addr", 32'(bus.address), 32'(exp_addr));
         check("pp_bank", 32'(bus.bank), 32'(exp_bank));
         check("pp_msb",  32'(bus.address[15]), 32'(exp_bank));
         check("pp_wrap", 32'(bus.wrap), 32'(i % 4 == 0 && i > 0));
         check("pp_last", 32'(bus.last), 32'(i % 4 == 3));
      end

      // Mid-pass reload at index 2
      set_cfg(0, 1, 7, 0);
      load = 1'b1; tick(); load = 1'b0;
      tick(); tick();
      check("mid_addr_idx2", 32'(bus.address), 8);
      set_cfg(100, 1, 0, 0);
      load = 1'b1; tick(); load = 1'b0;
      check("mid_addr", 32'(bus.address), 400);
      check("mid_wrap", 32'(bus.wrap), 0);
      check("mid_last", 32'(bus.last), 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("max0_addr", 32'(bus.address), 400);
         check("max0_last", 32'(bus.last), 1);
         check("max0_wrap", 32'(bus.wrap), 1);
      end

      // Load and halt together: load wins; then halt alone
      set_cfg(50, 2, 5, 0);
      load = 1'b1; halt = 1'b1; tick(); load = 1'b0;
      check("lh_valid", 32'(bus.valid), 1);
      check("lh_addr",  32'(bus.address), 200);
      check("lh_last",  32'(bus.last), 0);
      tick();
      check("halt_valid", 32'(bus.valid), 0);
      check("halt_done",  32'(bus.done), 0);
      halt = 1'b0; tick();
      check("halt_stay_idle", 32'(bus.valid), 0);

      // Asynchronous reset mid-pass with bank set
      set_cfg(10, 1, 0, 2);
      load = 1'b1; tick(); load = 1'b0;
      check("pp0_addr", 32'(bus.address), 40);
      tick();
      check("pp1_addr", 32'(bus.address), 32'(32768 + 40));
      check("pp1_bank", 32'(bus.bank), 1);
      #2 resetn = 1'b0;
      #1;
      check("arst_valid", 32'(bus.valid), 0);
      check("arst_addr",  32'(bus.address), 0);
      check("arst_bank",  32'(bus.bank), 0);
      check("arst_wrap",  32'(bus.wrap), 0);
      check("arst_last",  32'(bus.last), 0);
      tick();
      resetn = 1'b1;
      tick(); tick();
      check("post_rst_valid", 32'(bus.valid), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/address_sequencer.md
# address_sequencer

Parametrised successor to the BRAM address counter. It produces a byte-aligned address stream over a programmable window: start, stride, length, and a mode of continuous, single-shot or ping-pong. Each address is delivered with a valid/ready handshake and carries last/wrap flags. It sits between a control register bank and a BRAM port or DMA front end, feeding DAC playback, ADC capture and double-buffered acquisition.

## Interface
- COUNT_WIDTH, 13, width of index, start, stride and pointer
- ADDR_LSB, 2, number of zero bits appended (byte addressing)
- clk  in  1  single clock; all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- cfg_start  in  COUNT_WIDTH  first word pointer
- cfg_step  in  COUNT_WIDTH  pointer increment per beat, modulo 2^COUNT_WIDTH
- cfg_count_max  in  COUNT_WIDTH  beats per pass minus one
- cfg_mode  in  2  0 CONTINUOUS, 1 SINGLE, 2 PINGPONG, 3 treated as SINGLE
- load  in  1  latch all cfg_* and start a pass from index 0
- halt  in  1  stop output, return to IDLE
- ready  in  1  sink accepts the current address
- address  out  COUNT_WIDTH+ADDR_LSB+1  {bank, ptr, ADDR_LSB zeros}
- valid  out  1  address is presented
- last  out  1  current beat is index == count_max of the pass
- wrap  out  1  one-cycle pulse, new pass began
- done  out  1  level, SINGLE pass complete
- bank  out  1  ping-pong half; always 0 outside PINGPONG

## Operation
- Registered state: start_r, step_r, max_r, mode_r, index, ptr, bank, and state in {IDLE, RUN, DONE}.
- Reset: state IDLE; every output 0; all config registers 0.
- Beat accepted means valid && ready. Stalls (ready=0) hold address, last and index unchanged.
- IDLE or DONE with load:
  - latch config
  - index=0, ptr=cfg_start, bank=0
  - done=0, state goes to RUN
- RUN with load: identical restart, abandoning the current pass. No wrap pulse is issued.
- RUN, accepted beat with index != max_r: index+1, ptr = ptr + step_r. The sum wraps modulo 2^COUNT_WIDTH with no saturation.
- RUN, accepted beat with index == max_r:
  - CONTINUOUS: index=0, ptr=start_r, wrap=1.
  - PINGPONG: as CONTINUOUS, and bank toggles.
  - SINGLE: state goes to DONE, valid=0, done=1. done holds until load.
- halt from any state with load=0: state goes to IDLE, valid=0, done=0. Config and bank are kept.
- load and halt in the same cycle: load wins.
- valid = (state == RUN). last = valid && (index == max_r).
- max_r = 0: every beat is last. CONTINUOUS pulses wrap on every accepted beat; PINGPONG toggles bank on every accepted beat.
- step_r = 0: the address stays constant for the whole pass.
- cfg_* changes without load have no effect.

## Timing
- All outputs are registered. No combinational input-to-output path, including ready to valid.
- load sampled at edge k: at edge k+1 valid=1, address={0, cfg_start, 0s}, last=(cfg_count_max==0).
- Throughput is one address per cycle while ready=1.
- Beat accepted at edge k: the next address appears after edge k.
- wrap is high for exactly the one cycle following acceptance of the last beat. It coincides with the first address of the new pass.
- SINGLE: after edge k (final beat accepted), valid=0 and done=1 from edge k on.
- halt at edge k: valid=0 after edge k.
- resetn deassertion is asynchronous-assert, synchronised-release by the system. No output toggles until the first load.

## Structure
- Package address_sequencer_pkg:
  - mode_t enum: CONTINUOUS=2'd0, SINGLE=2'd1, PINGPONG=2'd2
  - state_t enum: IDLE, RUN, DONE
  - localparam ADDR_WIDTH = COUNT_WIDTH+ADDR_LSB+1, provided as a function of the parameters.
- Single module, no sub-module. The pointer accumulator and index counter are small enough to keep inline.

## Test plan
- Reset, then load with start=4, step=1, max=3, CONTINUOUS, ready=1.
  - Required: address 16,20,24,28,16…
  - last on the 28 beat; wrap on each return to 16; bank=0.
- SINGLE with start=0, step=3, max=2, ready toggling 1,0,1,1.
  - Required: addresses 0,12,24, each held during stalls.
  - Then valid=0 and done=1 stay held for 10 idle cycles.
- PINGPONG, COUNT_WIDTH=13, start=8190, step=1, max=3.
  - Required: ptr 8190,8191,0,1, i.e. modulo wrap.
  - bank toggles 0 to 1 at the pass boundary; address MSB follows bank.
- Mid-pass load of start=100, max=0, CONTINUOUS at index 2.
  - Required: the next address is 400 with no wrap pulse.
  - Afterwards, last and wrap are high on every beat.
- Simultaneous load and halt, then halt alone, then resetn asserted mid-pass.
  - load wins; halt gives valid=0 in 1 cycle.
  - resetn asserted mid-pass clears all outputs immediately, without waiting for a clock edge.
